seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Time-multiplexed scanner for an N-digit 7-segment+DP display. It replaces the external
//  digit-select counter with an internal slot timer and rotates through NUM_DIGITS digits.
//  Each slot starts with a dead-time blank to suppress ghosting.
//  Sits between the digit-encoding logic (per-digit segment bytes) and the display pins.
// PARAMETERS
//  NUM_DIGITS  4     number of digits scanned, 2..16
//  DIV         1000  clocks per digit slot; DIV >= BLANK+2
//  BLANK       16    dead-time clocks at start of every slot, digits all off; 0 allowed
//  (localparam IDXW = $clog2(NUM_DIGITS))
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  rst        in   1             synchronous reset, active-high
//  en         in   1             scan enable; low = display dark, scanner parked
//  seg_data   in   NUM_DIGITS*8  segment bytes; digit i at [8i+7:8i]
//  dig        out  NUM_DIGITS    digit enables, active-low one-cold (digit 0 -> ...1110)
//  sgm        out  8             segment pattern of current digit, passed through unmodified
//  idx        out  IDXW          index of digit owning the current slot
//  frame_start out 1             1-cycle pulse in first cycle of digit-0 slot
// BEHAVIOUR
//  - All outputs registered. Reset values: dig = all ones, sgm = 8'h00, idx = 0, frame_start = 0.
//  - Internal state: slot_cnt 0..DIV-1, idx 0..NUM_DIGITS-1.
//  - The scanner has two states: PARK (rst or en=0) and SCAN.
//  - PARK: slot_cnt = 0, idx = 0, dig = all ones, frame_start = 0, sgm holds.
//  - E0 = first rising edge with rst=0 and en=1 while parked. That edge starts slot 0:
//    - sgm <= seg_data[7:0] sampled at E0.
//    - idx <= 0; frame_start = 1 for one cycle.
//  - Slot k starts at edge E0 + k*DIV.
//    - At that edge sgm loads byte idx of seg_data. sgm stays stable for the whole slot, so no tearing.
//    - dig = all ones for BLANK cycles.
//    - Then dig[idx] = 0 (others 1) for DIV-BLANK cycles.
//  - idx advances at every slot boundary and wraps NUM_DIGITS-1 -> 0. Frame period = NUM_DIGITS*DIV clocks.
//  - seg_data changes mid-slot have no effect until the next slot boundary.
//  - en falls mid-slot: at the next edge the block enters PARK (dig all ones, counters cleared).
//    When en rises again, scanning restarts at digit 0 with a full blank.
//  - rst mid-operation: at the next edge all outputs take their reset values; slot/idx are cleared.
//  - At most one dig bit is low in any cycle. There is never an overlap between consecutive digits.
// CONFIGURATION
//  DIMMING_EN defined:
//    - Extra port `bright in 4` (brightness).
//    - A 4-bit pwm_cnt clears at slot start and increments every visible-window cycle.
//    - dig[idx] is low only when (bright==4'hF || pwm_cnt < bright).
//    - bright = 0 means dark. bright is sampled every cycle.
//  DIMMING_EN undefined: no bright port; the digit is fully on for its whole visible window.
// TESTING  (bench: NUM_DIGITS=4, DIV=8, BLANK=2)
//  - Reset: hold rst 3 cycles, en=1 -> dig=4'b1111, sgm=8'h00, idx=0, frame_start=0 while rst=1.
//  - Basic scan: release rst, en=1, seg_data=32'h44332211.
//    - E0: sgm=8'h11, frame_start=1.
//    - E0+2..E0+7: dig=4'b1110.
//    - E0+8: sgm=8'h22, dig=1111. E0+10: dig=4'b1101.
//    - E0+26: dig=4'b0111.
//    - E0+32: idx=0, frame_start=1 again.
//  - Wrap and stability: change seg_data to 32'hDDCCBBAA at E0+4 -> sgm stays 8'h11 until E0+8, then 8'hBB.
//  - Enable drop: en=0 at E0+12 -> from E0+13 dig=4'b1111, idx=0.
//    - en=1 two cycles later -> new slot 0 with 2-cycle blank, then dig=4'b1110.
//  - Reset mid-scan: rst=1 during digit 2 visible window -> next edge dig=1111, sgm=00, idx=0.
//    - After release, scanning restarts at digit 0.
//  - DIMMING_EN, bright=4 (visible window 6 cycles, pwm_cnt 0..5):
//    - dig[idx] low for pwm_cnt 0..3 (4 cycles), high for 2.
//    - bright=0 -> dig always 1111. bright=15 -> low for all 6 cycles.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment+DP scanner with a per-slot dead-time blank.
// Optional brightness PWM on the visible window is enabled by defining DIMMING_EN.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK      = 16,
  localparam int IDXW      = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_DIGITS*8-1:0] seg_data,
`ifdef DIMMING_EN
  input  logic [3:0]              bright,
`endif
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [7:0]              sgm,
  output logic [IDXW-1:0]         idx,
  output logic                    frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(DIV - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);

  typedef enum logic {PARK, SCAN} state_t;

  state_t                 state;
  logic [CW-1:0]          slot_cnt;
  logic [CW-1:0]          next_cnt;
  logic [IDXW-1:0]        next_idx;
  logic                   slot_start;
  logic                   visible;
  logic                   lit;
  logic [NUM_DIGITS-1:0]  next_dig;
`ifdef DIMMING_EN
  logic [3:0]             pwm_cnt;
  logic [3:0]             next_pwm;
`endif

  // Values the counters and outputs take at the coming edge; leaving PARK always opens slot 0.
  always_comb begin
    next_cnt   = '0;
    next_idx   = '0;
    slot_start = 1'b1;
    if (state == SCAN) begin
      slot_start = (slot_cnt == LAST_CNT);
      next_cnt   = slot_start ? '0 : slot_cnt + 1'b1;
      if (slot_start)
        next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      else
        next_idx = idx;
    end
    visible = (int'(next_cnt) >= BLANK);
`ifdef DIMMING_EN
    next_pwm = (int'(next_cnt) <= BLANK) ? 4'd0 : pwm_cnt + 4'd1;
    lit      = visible && ((bright == 4'hF) || (next_pwm < bright));
`else
    lit      = visible;
`endif
    next_dig = lit ? ~(NUM_DIGITS'(1) << next_idx) : '1;
  end

  // Scanner FSM; sgm only reloads at slot boundaries so a slot never shows a torn byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PARK;
      slot_cnt    <= '0;
      idx         <= '0;
      dig         <= '1;
      sgm         <= 8'h00;
      frame_start <= 1'b0;
`ifdef DIMMING_EN
      pwm_cnt     <= '0;
`endif
    end else if (!en) begin
      state       <= PARK;
      slot_cnt    <= '0;
      idx         <= '0;
      dig         <= '1;
      frame_start <= 1'b0;
`ifdef DIMMING_EN
      pwm_cnt     <= '0;
`endif
    end else begin
      state       <= SCAN;
      slot_cnt    <= next_cnt;
      idx         <= next_idx;
      dig         <= next_dig;
      frame_start <= slot_start && (next_idx == '0);
      if (slot_start)
        sgm <= seg_data[{next_idx, 3'b000} +: 8];
`ifdef DIMMING_EN
      pwm_cnt     <= next_pwm;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (NUM_DIGITS=4, DIV=8, BLANK=2, default build).
// Expected outputs come from a time-based model and are checked by a separate monitor.
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] sgm;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] seg_data;
  logic [3:0]  dig;
  logic [7:0]  sgm;
  logic [1:0]  idx;
  logic        frame_start;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 0;

  bit        m_run = 0;
  int        m_t   = 0;
  logic [7:0] m_sgm = 8'h00;

  seg_scan_mux #(.NUM_DIGITS(N), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_data(seg_data),
    .dig(dig), .sgm(sgm), .idx(idx), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: outputs depend only on cycles elapsed since scanning (re)started.
  function automatic exp_t model(input logic r, input logic e, input logic [31:0] s);
    exp_t x;
    int   pos;
    int   d;
    if (r) begin
      m_run = 0;
      m_sgm = 8'h00;
      x = '{dig: 4'b1111, sgm: 8'h00, idx: 2'd0, fs: 1'b0};
    end else if (!e) begin
      m_run = 0;
      x = '{dig: 4'b1111, sgm: m_sgm, idx: 2'd0, fs: 1'b0};
    end else begin
      if (!m_run) begin
        m_run = 1;
        m_t   = 0;
      end else begin
        m_t = m_t + 1;
      end
      pos = m_t % DIV;
      d   = (m_t / DIV) % N;
      if (pos == 0) m_sgm = 8'((s >> (8 * d)) & 32'hFF);
      x.dig = (pos >= BLANK) ? ~(4'b0001 << d) : 4'b1111;
      x.sgm = m_sgm;
      x.idx = 2'(d);
      x.fs  = (pos == 0) && (d == 0);
    end
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic [31:0] s);
    @(negedge clk);
    rst      = r;
    en       = e;
    seg_data = s;
    expq.push_back(model(r, e, s));
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: one registered output set per clock, compared against the oldest expectation.
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        checkOutput("dig", {4'h0, dig}, {4'h0, x.dig});
        checkOutput("sgm", sgm, x.sgm);
        checkOutput("idx", {6'h0, idx}, {6'h0, x.idx});
        checkOutput("frame_start", {7'h0, frame_start}, {7'h0, x.fs});
      end
    end
  end

  initial begin
    logic [31:0] s;
    logic        r;
    logic        e;
    rst = 1'b1;
    en = 1'b1;
    seg_data = 32'h44332211;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h44332211);

    // Basic scan with a mid-slot data change, then an enable drop at E0+12.
    for (int i = 0; i <= 12; i++)
      applyStimulus(1'b0, 1'b1, (i < 4) ? 32'h44332211 : 32'hDDCCBBAA);
    applyStimulus(1'b0, 1'b0, 32'hDDCCBBAA);
    applyStimulus(1'b0, 1'b0, 32'hDDCCBBAA);

    // Restart, run into digit 2 visible window, reset there, then restart again.
    for (int i = 0; i < 21; i++) applyStimulus(1'b0, 1'b1, 32'h44332211);
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 32'h44332211);

    // Randomized phase with occasional resets, enable drops and data changes.
    s = $urandom;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) s = $urandom;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 59) != 0);
      applyStimulus(r, e, s);
    end

    @(posedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
